afisaj_timer: RTL and testbench

//  Display stage downstream of the seconds/minutes counters. It samples the 6-bit

---
 rtl/afisaj_timer.sv | 149 ++++++++++++++
 tb/tb_afisaj_timer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/afisaj_timer.sv
// Display stage: converts captured seconds/minutes to BCD with a
// shift-add-3 FSM and scans a 4-digit common-anode 7-segment display.
module afisaj_timer #(
  parameter int DIV_SCAN = 50000,
  parameter int CNT_W    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] valoarea_bin,
  input  logic [5:0] minute_bin,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       bcd_valid
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV_SCAN - 1);

  logic [11:0]      s0;
  logic [11:0]      s1;
  logic [11:0]      last;
  logic [1:0]       state;
  logic [2:0]       sh_cnt;
  logic [5:0]       sec_bin;
  logic [5:0]       min_bin;
  logic [7:0]       sec_bcd;
  logic [7:0]       min_bcd;
  logic [7:0]       sec_adj;
  logic [7:0]       min_adj;
  logic [15:0]      disp;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [3:0]       nib;
  logic [6:0]       pat;

  function automatic logic [7:0] add3(input logic [7:0] b);
    logic [7:0] r;
    r = b;
    if (r[3:0] >= 4'd5) r[3:0] = r[3:0] + 4'd3;
    if (r[7:4] >= 4'd5) r[7:4] = r[7:4] + 4'd3;
    return r;
  endfunction

  always_comb begin
    sec_adj = add3(sec_bcd);
    min_adj = add3(min_bcd);
  end

  // s0/s1 agreement rejects words sampled mid-change from the slow domain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s0        <= '0;
      s1        <= '0;
      last      <= '0;
      state     <= IDLE;
      sh_cnt    <= '0;
      sec_bin   <= '0;
      min_bin   <= '0;
      sec_bcd   <= '0;
      min_bcd   <= '0;
      disp      <= '0;
      bcd_valid <= 1'b0;
    end else begin
      s0        <= {minute_bin, valoarea_bin};
      s1        <= s0;
      bcd_valid <= 1'b0;
      unique case (1'b1)
        state == IDLE: begin
          if (s0 == s1 && s1 != last) begin
            {min_bin, sec_bin} <= s1;
            last    <= s1;
            sec_bcd <= '0;
            min_bcd <= '0;
            sh_cnt  <= '0;
            state   <= SHIFT;
          end
        end
        state == SHIFT: begin
          sec_bcd <= {sec_adj[6:0], sec_bin[5]};
          min_bcd <= {min_adj[6:0], min_bin[5]};
          sec_bin <= {sec_bin[4:0], 1'b0};
          min_bin <= {min_bin[4:0], 1'b0};
          sh_cnt  <= sh_cnt + 3'd1;
          if (sh_cnt == 3'd5) state <= COMMIT;
        end
        state == COMMIT: begin
          disp      <= {min_bcd, sec_bcd};
          bcd_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    nib = disp[3:0];
    unique case (idx)
      2'd0: nib = disp[3:0];
      2'd1: nib = disp[7:4];
      2'd2: nib = disp[11:8];
      2'd3: nib = disp[15:12];
      default: nib = disp[3:0];
    endcase
  end

  always_comb begin
    pat = 7'h7F;
    case (nib)
      4'd0: pat = 7'h40;
      4'd1: pat = 7'h79;
      4'd2: pat = 7'h24;
      4'd3: pat = 7'h30;
      4'd4: pat = 7'h19;
      4'd5: pat = 7'h12;
      4'd6: pat = 7'h02;
      4'd7: pat = 7'h78;
      4'd8: pat = 7'h00;
      4'd9: pat = 7'h10;
      default: pat = 7'h7F;
    endcase
  end

  // slot start (cnt==0) is blanked so the anode switch never ghosts
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      idx <= '0;
      an  <= 4'hF;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      if (cnt == CNT_MAX) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      an  <= (cnt == '0) ? 4'hF : ~(4'b0001 << idx);
      seg <= (cnt == '0) ? 7'h7F : pat;
      dp  <= !(idx == 2'd2 && cnt != '0);
    end
  end

endmodule

// File: tb/tb_afisaj_timer.sv
// Bench for afisaj_timer: directed and random inputs against an
// arithmetic reference model of capture, conversion and scanning.
module tb_afisaj_timer;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] sec;
  logic [5:0] mins;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       bcd_valid;

  always #5 clk = ~clk;

  afisaj_timer #(.DIV_SCAN(D), .CNT_W(3)) dut (
    .clk(clk),
    .reset(reset),
    .valoarea_bin(sec),
    .minute_bin(mins),
    .seg(seg),
    .dp(dp),
    .an(an),
    .bcd_valid(bcd_valid)
  );

  int total = 0;
  int bad = 0;
  int k;
  int commit_at;
  int pulses;
  logic [11:0] m_s0, m_s1, last, conv;
  int dsp[4];

  function automatic logic [6:0] seven(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    k = 0;
    m_s0 = '0;
    m_s1 = '0;
    last = '0;
    commit_at = -1;
    for (int i = 0; i < 4; i++) dsp[i] = 0;
  endtask

  task automatic check_reset_now(input string tag);
    chk({tag, "_an"}, 16'(an), 16'hF);
    chk({tag, "_seg"}, 16'(seg), 16'h7F);
    chk({tag, "_dp"}, 16'(dp), 16'h1);
    chk({tag, "_valid"}, 16'(bcd_valid), 16'h0);
  endtask

  task automatic step();
    int c, ix, mv, sv;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic e_dp, e_valid;
    @(posedge clk);
    k++;
    c  = (k - 1) % D;
    ix = ((k - 1) / D) % 4;
    e_an  = (c == 0) ? 4'hF : ~(4'b0001 << ix);
    e_seg = (c == 0) ? 7'h7F : seven(dsp[ix]);
    e_dp  = !(ix == 2 && c != 0);
    e_valid = 1'b0;
    if (commit_at == k) begin
      mv = int'(conv[11:6]);
      sv = int'(conv[5:0]);
      dsp[0] = sv % 10;
      dsp[1] = sv / 10;
      dsp[2] = mv % 10;
      dsp[3] = mv / 10;
      e_valid = 1'b1;
      commit_at = -1;
    end else if (commit_at < 0 && m_s0 == m_s1 && m_s1 != last) begin
      conv = m_s1;
      last = m_s1;
      commit_at = k + 7;
    end
    m_s1 = m_s0;
    m_s0 = {mins, sec};
    #1;
    chk("an", 16'(an), 16'(e_an));
    chk("seg", 16'(seg), 16'(e_seg));
    chk("dp", 16'(dp), 16'(e_dp));
    chk("bcd_valid", 16'(bcd_valid), 16'(e_valid));
    if (bcd_valid === 1'b1) pulses++;
  endtask

  task automatic drive(input int m, input int s);
    @(negedge clk);
    mins = 6'(m);
    sec  = 6'(s);
  endtask

  task automatic enter_reset(input string tag);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_now(tag);
    model_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check_reset_now(tag);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic measure_lat(input string tag);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    for (int i = 1; i <= 30 && !seen; i++) begin
      step();
      if (bcd_valid === 1'b1) begin
        seen = 1;
        n = i;
      end
    end
    chk(tag, 16'(n), 16'd10);
  endtask

  task automatic wait_shift(input int left, input string tag);
    bit hit;
    hit = 0;
    for (int i = 0; i < 30 && !hit; i++) begin
      step();
      if (commit_at >= 0 && commit_at - k == left) hit = 1;
    end
    chk(tag, 16'(hit), 16'h1);
  endtask

  initial begin
    reset = 1'b1;
    mins = 6'd7;
    sec = 6'd45;
    pulses = 0;
    model_reset();
    #2;
    reset = 1'b0;
    #1;
    check_reset_now("t1_reset");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_reset_now("t1_hold");
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (30) step();

    drive(12, 45);
    measure_lat("t2_latency");
    repeat (30) step();

    mins = 6'd0;
    sec = 6'd0;
    enter_reset("t3_reset");
    pulses = 0;
    repeat (30) step();
    chk("t3_zero_no_conv", 16'(pulses), 16'd0);
    drive(63, 59);
    repeat (25) step();
    drive(9, 10);
    repeat (25) step();

    drive(20, 30);
    pulses = 0;
    wait_shift(5, "t4_reach_shift");
    drive(20, 31);
    repeat (40) step();
    chk("t4_pulses", 16'(pulses), 16'd2);

    drive(33, 17);
    wait_shift(3, "t6_reach_shift");
    enter_reset("t6_reset");
    measure_lat("t6_latency");
    repeat (20) step();

    for (int r = 0; r < 25; r++) begin
      drive(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
      repeat (int'($urandom_range(1, 24))) step();
    end
    repeat (20) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
